// File: rtl/xm_mc_sequencer.sv
// xm_mc_sequencer
//   Multi-cycle control sequencer for the XM core. It sits between the
//   instruction decoder and the datapath and steps each instruction through
//   fetch, decode, execute and, for loads and stores, a memory access. Memory
//   uses a req/ack handshake. Each access may wait at most MEM_TIMEOUT cycles
//   before it is treated as a bus fault. Exceptions (IRQ, trap, illegal op,
//   bus fault) enter through EXC_ENTRY. A bus fault while fetching the vector
//   instruction halts the core until reset.
//
// Ports
//   clk_i        clock, rising edge
//   arst_i       asynchronous reset, active high
//   instClass_i  decoded class (0 ALU,1 CBRANCH,2 LBRANCH,3 LOAD,4 STORE,5 IMM,6 TRAP,7 ILLEGAL)
//   branchRes_i  conditional-branch result
//   irq_i        level interrupt request
//   irqEn_i      global interrupt enable
//   memAck_i     memory access complete
//   memReq_o     memory request
//   memRW_o      0 read, 1 write
//   irWr_o       instruction register load strobe
//   pcWr_o       PC write strobe
//   pcSel_o      0 PC+2, 1 branch target, 2 exception vector
//   regWr_o      register file write strobe
//   regWrSel_o   0 ALU, 1 PC, 2 MEM, 3 IMM
//   regWrAdr_o   write address override (LR on link/exception)
//   flagsWr_o    flags write strobe
//   excCause_o   0 IRQ, 1 TRAP, 2 ILLEGAL, 3 BUSFAULT; valid in EXC_ENTRY
//   excTaken_o   one-cycle pulse in EXC_ENTRY
//   halted_o     double-fault halt
//
// state       | meaning
// ------------+-----------------------------------------------------------
// EXC_CHECK   | sample irq_i & irqEn_i between instructions
// FETCH       | instruction read, wait for ack or timeout
// DECODE      | latch class, divert traps / illegal ops
// EXEC        | ALU, branch, IMM write-back; start of load/store
// MEM         | data access, wait for ack or timeout
// MEM_WB      | load data write-back
// EXC_ENTRY   | save PC to LR, load vector, pulse excTaken_o
// HALT        | fault during vector fetch; left only through reset

module xm_mc_sequencer #(
  parameter int unsigned WORD        = 16,
  parameter int unsigned LR          = 5,
  parameter int unsigned PC          = 7,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned EXC_VEC_W   = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [2:0]           instClass_i,
  input  logic                 branchRes_i,
  input  logic                 irq_i,
  input  logic                 irqEn_i,
  input  logic                 memAck_i,
  output logic                 memReq_o,
  output logic                 memRW_o,
  output logic                 irWr_o,
  output logic                 pcWr_o,
  output logic [1:0]           pcSel_o,
  output logic                 regWr_o,
  output logic [2:0]           regWrSel_o,
  output logic [2:0]           regWrAdr_o,
  output logic                 flagsWr_o,
  output logic [EXC_VEC_W-1:0] excCause_o,
  output logic                 excTaken_o,
  output logic                 halted_o
);

  if (WORD < 8 || LR > 7 || PC > 7 || LR == PC || MEM_TIMEOUT < 1 || EXC_VEC_W < 2) begin : g_bad_cfg
    $error("xm_mc_sequencer: unsupported parameter set");
  end

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_TIMEOUT);
  localparam logic [2:0] LR_ADR = 3'(LR);

  localparam logic [2:0] CLS_ALU     = 3'd0;
  localparam logic [2:0] CLS_CBRANCH = 3'd1;
  localparam logic [2:0] CLS_LBRANCH = 3'd2;
  localparam logic [2:0] CLS_LOAD    = 3'd3;
  localparam logic [2:0] CLS_STORE   = 3'd4;
  localparam logic [2:0] CLS_IMM     = 3'd5;
  localparam logic [2:0] CLS_TRAP    = 3'd6;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  localparam logic [EXC_VEC_W-1:0] CAUSE_IRQ     = EXC_VEC_W'(0);
  localparam logic [EXC_VEC_W-1:0] CAUSE_TRAP    = EXC_VEC_W'(1);
  localparam logic [EXC_VEC_W-1:0] CAUSE_ILLEGAL = EXC_VEC_W'(2);
  localparam logic [EXC_VEC_W-1:0] CAUSE_BUS     = EXC_VEC_W'(3);

  localparam logic [1:0] PCSEL_INC = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_VEC = 2'd2;

  localparam logic [2:0] WSEL_ALU = 3'd0;
  localparam logic [2:0] WSEL_PC  = 3'd1;
  localparam logic [2:0] WSEL_MEM = 3'd2;
  localparam logic [2:0] WSEL_IMM = 3'd3;

  typedef enum logic [2:0] {
    S_EXC_CHECK = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXEC      = 3'd3,
    S_MEM       = 3'd4,
    S_MEM_WB    = 3'd5,
    S_EXC_ENTRY = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             class_q, class_d;
  logic [EXC_VEC_W-1:0]   cause_q, cause_d;
  // Wait timer counts down from MEM_TIMEOUT; terminal count zero with no
  // ack is the bus fault. An ack at terminal count still completes.
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  // Set by EXC_ENTRY, cleared by a successful fetch: a fault while it is set
  // is a double fault.
  logic                   vec_fetch_q, vec_fetch_d;
  logic                   wait_tc;

  assign wait_tc = (wait_cnt_q == '0);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= S_EXC_CHECK;
      class_q     <= CLS_ALU;
      cause_q     <= CAUSE_IRQ;
      wait_cnt_q  <= '0;
      vec_fetch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      cause_q     <= cause_d;
      wait_cnt_q  <= wait_cnt_d;
      vec_fetch_q <= vec_fetch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    cause_d     = cause_q;
    wait_cnt_d  = wait_cnt_q;
    vec_fetch_d = vec_fetch_q;
    memReq_o    = 1'b0;
    memRW_o     = 1'b0;
    irWr_o      = 1'b0;
    pcWr_o      = 1'b0;
    pcSel_o     = PCSEL_INC;
    regWr_o     = 1'b0;
    regWrSel_o  = WSEL_ALU;
    regWrAdr_o  = 3'd0;
    flagsWr_o   = 1'b0;
    excCause_o  = '0;
    excTaken_o  = 1'b0;
    halted_o    = 1'b0;

    case (state_q)
      S_EXC_CHECK: begin
        if (irq_i && irqEn_i) begin
          cause_d = CAUSE_IRQ;
          state_d = S_EXC_ENTRY;
        end else begin
          wait_cnt_d = CNT_LOAD;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        memReq_o = 1'b1;
        if (memAck_i) begin
          irWr_o      = 1'b1;
          pcWr_o      = 1'b1;
          pcSel_o     = PCSEL_INC;
          vec_fetch_d = 1'b0;
          state_d     = S_DECODE;
        end else if (wait_tc) begin
          if (vec_fetch_q) begin
            state_d = S_HALT;
          end else begin
            cause_d = CAUSE_BUS;
            state_d = S_EXC_ENTRY;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end

      S_DECODE: begin
        class_d = instClass_i;
        if (instClass_i == CLS_TRAP) begin
          cause_d = CAUSE_TRAP;
          state_d = S_EXC_ENTRY;
        end else if (instClass_i == CLS_ILLEGAL) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = S_EXC_ENTRY;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_EXC_CHECK;
        case (class_q)
          CLS_ALU: begin
            regWr_o    = 1'b1;
            regWrSel_o = WSEL_ALU;
            flagsWr_o  = 1'b1;
          end
          CLS_CBRANCH: begin
            pcWr_o  = branchRes_i;
            pcSel_o = PCSEL_BR;
          end
          CLS_LBRANCH: begin
            pcWr_o     = 1'b1;
            pcSel_o    = PCSEL_BR;
            regWr_o    = 1'b1;
            regWrSel_o = WSEL_PC;
            regWrAdr_o = LR_ADR;
          end
          CLS_IMM: begin
            regWr_o    = 1'b1;
            regWrSel_o = WSEL_IMM;
          end
          CLS_LOAD, CLS_STORE: begin
            wait_cnt_d = CNT_LOAD;
            state_d    = S_MEM;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        memReq_o = 1'b1;
        memRW_o  = (class_q == CLS_STORE);
        if (memAck_i) begin
          state_d = (class_q == CLS_STORE) ? S_EXC_CHECK : S_MEM_WB;
        end else if (wait_tc) begin
          cause_d = CAUSE_BUS;
          state_d = S_EXC_ENTRY;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end

      S_MEM_WB: begin
        regWr_o    = 1'b1;
        regWrSel_o = WSEL_MEM;
        state_d    = S_EXC_CHECK;
      end

      S_EXC_ENTRY: begin
        regWr_o     = 1'b1;
        regWrSel_o  = WSEL_PC;
        regWrAdr_o  = LR_ADR;
        pcWr_o      = 1'b1;
        pcSel_o     = PCSEL_VEC;
        excCause_o  = cause_q;
        excTaken_o  = 1'b1;
        vec_fetch_d = 1'b1;
        wait_cnt_d  = CNT_LOAD;
        state_d     = S_FETCH;
      end

      S_HALT: begin
        halted_o = 1'b1;
      end

      default: state_d = S_EXC_CHECK;
    endcase
  end

endmodule

// File: tb/tb_xm_mc_sequencer.sv
// Randomized bench for xm_mc_sequencer. A reference model expands each
// instruction into the expected per-cycle trace of strobes (from the class,
// the memory wait chosen and the interrupt inputs). The trace is then replayed
// against the DUT cycle by cycle.

module tb_xm_mc_sequencer;

  localparam int unsigned T      = 15;
  localparam logic [2:0]  LR_ADR = 3'd5;

  logic       clk_i = 1'b0;
  logic       arst_i;
  logic [2:0] instClass_i;
  logic       branchRes_i, irq_i, irqEn_i, memAck_i;
  logic       memReq_o, memRW_o, irWr_o, pcWr_o;
  logic [1:0] pcSel_o;
  logic       regWr_o;
  logic [2:0] regWrSel_o, regWrAdr_o;
  logic       flagsWr_o;
  logic [1:0] excCause_o;
  logic       excTaken_o, halted_o;

  always #5 clk_i = ~clk_i;

  xm_mc_sequencer #(
    .WORD(16), .LR(5), .PC(7), .MEM_TIMEOUT(T), .EXC_VEC_W(2)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i), .instClass_i(instClass_i),
    .branchRes_i(branchRes_i), .irq_i(irq_i), .irqEn_i(irqEn_i),
    .memAck_i(memAck_i), .memReq_o(memReq_o), .memRW_o(memRW_o),
    .irWr_o(irWr_o), .pcWr_o(pcWr_o), .pcSel_o(pcSel_o), .regWr_o(regWr_o),
    .regWrSel_o(regWrSel_o), .regWrAdr_o(regWrAdr_o), .flagsWr_o(flagsWr_o),
    .excCause_o(excCause_o), .excTaken_o(excTaken_o), .halted_o(halted_o)
  );

  typedef struct {
    bit       ack;
    bit [2:0] cls;
    bit       br, irq, en;
    bit       mreq, mrw, irwr, pcwr;
    bit [1:0] pcsel;
    bit       regwr;
    bit [2:0] wsel;
    bit       lr;
    bit       flw, taken;
    bit [1:0] cause;
    bit       halted;
  } cyc_t;

  cyc_t        q[$];
  int unsigned fw_q[$];
  bit [2:0]    fc_q[$];
  bit [1:0]    fi_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit [2:0]    cur_cls = 3'd0;
  bit          vec = 1'b0;
  bit          halted_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic cyc_t blank();
    cyc_t c;
    c = '{default: 0};
    c.cls = cur_cls;
    c.br  = 1'($urandom);
    c.irq = 1'($urandom);
    c.en  = 1'($urandom);
    return c;
  endfunction

  task automatic pick_wait(output int unsigned w);
    int unsigned r;
    if (fw_q.size() != 0) begin
      w = fw_q.pop_front();
    end else begin
      r = $urandom_range(0, 19);
      if (r < 12)      w = $urandom_range(0, 3);
      else if (r < 15) w = T;
      else if (r < 17) w = $urandom_range(4, T - 1);
      else             w = T + 1;
    end
  endtask

  task automatic push_entry(input bit [1:0] cause);
    cyc_t c;
    c = blank();
    c.regwr = 1; c.wsel = 3'd1; c.lr = 1;
    c.pcwr = 1; c.pcsel = 2'd2;
    c.taken = 1; c.cause = cause;
    q.push_back(c);
    vec = 1'b1;
  endtask

  // Expected trace from one EXC_CHECK to the next (or into the halt).
  task automatic gen_instr();
    cyc_t        c;
    int unsigned w;
    bit [1:0]    ie;
    bit          done;
    done = 1'b0;
    vec  = 1'b0;
    c = blank();
    if (fi_q.size() != 0) ie = fi_q.pop_front();
    else                  ie = 2'($urandom);
    c.irq = ie[1];
    c.en  = ie[0];
    q.push_back(c);
    if (ie == 2'b11) push_entry(2'd0);
    while (!done) begin
      pick_wait(w);
      for (int k = 0; k <= int'(T) && k < int'(w); k++) begin
        c = blank(); c.mreq = 1; q.push_back(c);
      end
      if (w > T) begin
        if (vec) begin
          for (int k = 0; k < 20; k++) begin
            c = blank(); c.halted = 1; q.push_back(c);
          end
          halted_m = 1'b1;
          return;
        end
        push_entry(2'd3);
        continue;
      end
      c = blank(); c.ack = 1; c.mreq = 1; c.irwr = 1; c.pcwr = 1; q.push_back(c);
      vec = 1'b0;
      if (fc_q.size() != 0) cur_cls = fc_q.pop_front();
      else                  cur_cls = 3'($urandom);
      c = blank(); q.push_back(c);
      if (cur_cls == 3'd6) begin push_entry(2'd1); continue; end
      if (cur_cls == 3'd7) begin push_entry(2'd2); continue; end
      c = blank();
      case (cur_cls)
        3'd0: begin c.regwr = 1; c.flw = 1; end
        3'd1: begin c.pcwr = c.br; c.pcsel = 2'd1; end
        3'd2: begin c.pcwr = 1; c.pcsel = 2'd1; c.regwr = 1; c.wsel = 3'd1; c.lr = 1; end
        3'd5: begin c.regwr = 1; c.wsel = 3'd3; end
        default: ;
      endcase
      q.push_back(c);
      if (cur_cls == 3'd3 || cur_cls == 3'd4) begin
        pick_wait(w);
        for (int k = 0; k <= int'(T) && k < int'(w); k++) begin
          c = blank(); c.mreq = 1; c.mrw = (cur_cls == 3'd4); q.push_back(c);
        end
        if (w > T) begin
          push_entry(2'd3);
          continue;
        end
        c = blank(); c.ack = 1; c.mreq = 1; c.mrw = (cur_cls == 3'd4); q.push_back(c);
        if (cur_cls == 3'd3) begin
          c = blank(); c.regwr = 1; c.wsel = 3'd2; q.push_back(c);
        end
      end
      done = 1'b1;
    end
  endtask

  task automatic apply_queue();
    cyc_t c;
    while (q.size() != 0) begin
      c = q.pop_front();
      memAck_i    = c.ack;
      instClass_i = c.cls;
      branchRes_i = c.br;
      irq_i       = c.irq;
      irqEn_i     = c.en;
      @(negedge clk_i);
      chk("strobes",
          32'({memReq_o, irWr_o, pcWr_o, pcSel_o, regWr_o, flagsWr_o, excTaken_o, halted_o}),
          32'({c.mreq, c.irwr, c.pcwr, c.pcsel, c.regwr, c.flw, c.taken, c.halted}));
      if (c.mreq)          chk("memRW", 32'(memRW_o), 32'(c.mrw));
      if (c.regwr)         chk("regWrSel", 32'(regWrSel_o), 32'(c.wsel));
      if (c.regwr && c.lr) chk("regWrAdr", 32'(regWrAdr_o), 32'(LR_ADR));
      if (c.taken)         chk("excCause", 32'(excCause_o), 32'(c.cause));
      @(posedge clk_i);
      #1;
    end
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic pulse_reset_check(input string tag);
    arst_i = 1'b1;
    #2;
    chk({tag, "_strobes"},
        32'({memReq_o, irWr_o, pcWr_o, pcSel_o, regWr_o, flagsWr_o, excTaken_o, halted_o}), 32'd0);
    chk({tag, "_cause"}, 32'(excCause_o), 32'd0);
    @(posedge clk_i);
    #1;
    arst_i = 1'b0;
  endtask

  initial begin
    arst_i = 1'b1; instClass_i = 3'd0; branchRes_i = 1'b0;
    irq_i = 1'b0; irqEn_i = 1'b0; memAck_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_strobes",
        32'({memReq_o, irWr_o, pcWr_o, pcSel_o, regWr_o, flagsWr_o, excTaken_o, halted_o}), 32'd0);
    chk("reset_cause", 32'(excCause_o), 32'd0);
    arst_i = 1'b0;

    // EXC_CHECK, then a fetch left waiting and reset in the middle of it.
    @(negedge clk_i);
    chk("exc_check_idle", 32'(memReq_o), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("fetch_req", 32'(memReq_o), 32'd1);
    @(posedge clk_i); #1;
    pulse_reset_check("midreq_rst");

    // Directed boundary cases first, then free-running random.
    fw_q = '{0, 0, 3, 0, 16, 0, 15, 0, 0, 0, 0, 16};
    fc_q = '{3'd0, 3'd3, 3'd3, 3'd4, 3'd6, 3'd0, 3'd2, 3'd7};
    fi_q = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};

    for (int i = 0; i < 400; i++) begin
      gen_instr();
      apply_queue();
      if (halted_m) begin
        pulse_reset_check("halt_rst");
        halted_m = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
